fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 30 +++
 rtl/ifid_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 68 ++++++
 tb/tb_fetch_stage.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   PC_W / INSTR_W / OPC_W : datapath widths
//   NOP                    : ADDI XZR,XZR,#0, used as the bubble instruction
//   RESET_VECTOR           : PC after reset
//   ifid_t                 : contents of the IF/ID pipeline register
package cpu_pkg;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 11;

  localparam logic [INSTR_W-1:0] NOP          = 32'h910003FF;
  localparam logic [PC_W-1:0]    RESET_VECTOR = 64'h0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its environment (control, imem, decode).
//   master : fetch_stage side (drives instr_addr and the IF/ID outputs)
//   slave  : environment side (drives stall/redirect and instruction data)
interface fetch_stage_if;
  import cpu_pkg::*;

  logic                 stall;
  logic                 branch_taken;
  logic [PC_W-1:0]      branch_target;
  logic [PC_W-1:0]      instr_addr;
  logic [INSTR_W-1:0]   instr_rdata;
  logic [INSTR_W-1:0]   ifid_instr;
  logic [PC_W-1:0]      ifid_pc;
  logic                 ifid_valid;
  logic [OPC_W-1:0]     ifid_opcode;
  logic [31:0]          fetch_count;
  logic [31:0]          flush_count;

  modport master (
    input  stall, branch_taken, branch_target, instr_rdata,
    output instr_addr, ifid_instr, ifid_pc, ifid_valid, ifid_opcode,
           fetch_count, flush_count
  );

  modport slave (
    output stall, branch_taken, branch_target, instr_rdata,
    input  instr_addr, ifid_instr, ifid_pc, ifid_valid, ifid_opcode,
           fetch_count, flush_count
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold and flush.
//   clk, reset : clock, synchronous active-high reset
//   hold_i     : keep current contents
//   flush_i    : load a bubble (NOP, valid=0) tagged with d_i.pc; beats hold_i
//   d_i        : fetched instruction record
//   q_o        : registered record presented to decode
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);
  ifid_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d.instr = NOP;
      q_d.pc    = d_i.pc;
      q_d.valid = 1'b0;
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q.instr <= NOP;
      q_q.pc    <= '0;
      q_q.valid <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux, IF/ID register and
// fetch/flush event counters.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_stage_if.master (stall/redirect in, imem addr/data,
//                IF/ID outputs, counters)
module fetch_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;
  logic [31:0]     flush_cnt_q, flush_cnt_d;
  logic            load_valid;
  ifid_t           ifid_d, ifid_q;

  // A redirect wins over a stall; only an unstalled, unredirected cycle
  // latches a real instruction.
  assign load_valid = !bus.branch_taken && !bus.stall;

  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.branch_taken) begin
      pc_d        = {bus.branch_target[PC_W-1:2], 2'b00};
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!bus.stall) begin
      pc_d        = pc_q + 64'd4;  // wraps naturally modulo 2^64
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ifid_d.instr = bus.instr_rdata;
  assign ifid_d.pc    = pc_q;
  assign ifid_d.valid = 1'b1;

  ifid_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .hold_i  (!load_valid),
    .flush_i (bus.branch_taken),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign bus.instr_addr  = pc_q;
  assign bus.ifid_instr  = ifid_q.instr;
  assign bus.ifid_pc     = ifid_q.pc;
  assign bus.ifid_valid  = ifid_q.valid;
  assign bus.ifid_opcode = ifid_q.instr[INSTR_W-1 -: OPC_W];
  assign bus.fetch_count = fetch_cnt_q;
  assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: each word is tagged with its own address.
  function automatic logic [31:0] memw(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  assign bus.instr_rdata = memw(bus.instr_addr);

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] addr, input logic [31:0] instr,
                         input logic [63:0] ipc, input logic vld,
                         input logic [31:0] fc, input logic [31:0] flc);
    chk({tag, ".instr_addr"},  bus.instr_addr, addr);
    chk({tag, ".ifid_instr"},  64'(bus.ifid_instr), 64'(instr));
    chk({tag, ".ifid_opcode"}, 64'(bus.ifid_opcode), 64'(instr[31:21]));
    chk({tag, ".ifid_pc"},     bus.ifid_pc, ipc);
    chk({tag, ".ifid_valid"},  64'(bus.ifid_valid), 64'(vld));
    chk({tag, ".fetch_count"}, 64'(bus.fetch_count), 64'(fc));
    chk({tag, ".flush_count"}, 64'(bus.flush_count), 64'(flc));
  endtask

  typedef struct {
    logic        rst, stl, br;
    logic [63:0] tgt;
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        vld;
    logic [31:0] fc, flc;
  } vec_t;

  function automatic vec_t mk(input logic rst, stl, br, input logic [63:0] tgt,
                              input logic [63:0] addr, input logic [31:0] instr,
                              input logic [63:0] ipc, input logic vld,
                              input logic [31:0] fc, flc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
    v.addr = addr; v.instr = instr; v.ipc = ipc; v.vld = vld; v.fc = fc; v.flc = flc;
    return v;
  endfunction

  vec_t vt[15];

  // Higher-level reference state for the random phase.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_fc, m_flc;
  logic        m_vld;

  initial begin
    //          rst stl br  target               addr                 instr                      ifid_pc              v  fc flc
    vt[0]  = mk(1, 0, 0, 64'h0,                64'h0,               NOP,                       64'h0,               0, 0, 0);
    vt[1]  = mk(0, 0, 0, 64'h0,                64'h4,               memw(64'h0),               64'h0,               1, 1, 0);
    vt[2]  = mk(0, 0, 0, 64'h0,                64'h8,               memw(64'h4),               64'h4,               1, 2, 0);
    vt[3]  = mk(0, 1, 0, 64'h0,                64'h8,               memw(64'h4),               64'h4,               1, 2, 0);
    vt[4]  = mk(0, 1, 0, 64'h0,                64'h8,               memw(64'h4),               64'h4,               1, 2, 0);
    vt[5]  = mk(0, 0, 0, 64'h0,                64'hC,               memw(64'h8),               64'h8,               1, 3, 0);
    vt[6]  = mk(0, 0, 1, 64'h103,              64'h100,             NOP,                       64'hC,               0, 3, 1);
    vt[7]  = mk(0, 0, 0, 64'h0,                64'h104,             memw(64'h100),             64'h100,             1, 4, 1);
    vt[8]  = mk(0, 1, 1, 64'h203,              64'h200,             NOP,                       64'h104,             0, 4, 2);
    vt[9]  = mk(0, 0, 0, 64'h0,                64'h204,             memw(64'h200),             64'h200,             1, 5, 2);
    vt[10] = mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, NOP,              64'h204,             0, 5, 3);
    vt[11] = mk(0, 0, 0, 64'h0,                64'h0,               memw(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 1, 6, 3);
    vt[12] = mk(0, 0, 1, 64'h40,               64'h40,              NOP,                       64'h0,               0, 6, 4);
    vt[13] = mk(1, 1, 1, 64'h80,               64'h0,               NOP,                       64'h0,               0, 0, 0);
    vt[14] = mk(0, 0, 0, 64'h0,                64'h4,               memw(64'h0),               64'h0,               1, 1, 0);

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      reset = vt[i].rst;
      bus.stall = vt[i].stl;
      bus.branch_taken = vt[i].br;
      bus.branch_target = vt[i].tgt;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].addr, vt[i].instr, vt[i].ipc, vt[i].vld,
              vt[i].fc, vt[i].flc);
    end

    // Hand sequence: redirect then immediate second redirect; the first
    // target is fetched only as a bubble tag, never as a valid word.
    @(negedge clk); reset = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 64'h1000;
    @(posedge clk); #1;
    @(negedge clk); bus.branch_target = 64'h2002;
    @(posedge clk); #1;
    chk("b2b.addr", bus.instr_addr, 64'h2000);
    chk("b2b.ifid_pc", bus.ifid_pc, 64'h1000);
    chk("b2b.valid", 64'(bus.ifid_valid), 64'h0);
    @(negedge clk); bus.branch_taken = 1'b0;
    @(posedge clk); #1;
    chk("b2b.target_word", 64'(bus.ifid_instr), 64'(memw(64'h2000)));

    // Random phase against the reference model, starting from a reset.
    m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP; m_vld = 1'b0; m_fc = 0; m_flc = 0;
    @(negedge clk); reset = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0;
    @(posedge clk); #1;
    chk_all("rnd_reset", m_pc, m_instr, m_ipc, m_vld, m_fc, m_flc);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 40) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        bus.branch_target = {$urandom, $urandom};

      if (reset) begin
        m_pc = RESET_VECTOR; m_instr = NOP; m_ipc = 64'h0; m_vld = 1'b0; m_fc = 0; m_flc = 0;
      end else if (bus.branch_taken) begin
        m_instr = NOP; m_ipc = m_pc; m_vld = 1'b0;
        m_pc = bus.branch_target & ~64'h3;
        m_flc = m_flc + 1;
      end else if (!bus.stall) begin
        m_instr = memw(m_pc); m_ipc = m_pc; m_vld = 1'b1;
        m_pc = m_pc + 64'd4;
        m_fc = m_fc + 1;
      end

      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_ipc, m_vld, m_fc, m_flc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
